lif_spike_rate_encoder: RTL and testbench
=========================================

// Module: lif_spike_rate_encoder
// PURPOSE
//   Transmit side of the LIF spike interface. Converts an 8-bit stimulus intensity
//   into a single-bit spike train, one spike = one clk-wide high pulse, over a fixed
//   window. Drives the neuron's signal_in.
//   Two modes:
//   - deterministic: phase accumulator, exact rate.
//   - stochastic: LFSR comparator, Poisson-like train.
//   Reports the number of spikes it emitted so the bench/host can close the loop
//   against the neuron's output.
// PARAMETERS
//   WIDTH      8         intensity / accumulator width (bits)
//   WINDOW     256       clk cycles per encoding window (>=2)
//   LFSR_SEED  16'hACE1  LFSR reset/start value (must be nonzero)
// PORTS
//   clk          in   1               system clock, all state on rising edge
//   rst_n        in   1               synchronous reset, active-low
//   ena          in   1               global enable; low = freeze
//   intensity    in   WIDTH           requested rate, sampled on start accept
//   mode         in   1               0=deterministic, 1=stochastic; sampled on start accept
//   start        in   1               request a new window (level-sensitive, one-shot accept)
//   spike_out    out  1               spike train to neuron signal_in
//   busy         out  1               window in progress
//   done         out  1               one-cycle pulse after the last window cycle
//   spike_count  out  $clog2(WINDOW+1)  spikes emitted in the last/current window
// BEHAVIOUR
//   - Reset: rst_n sampled low at posedge clears state.
//     - Outputs: spike_out=0, busy=0, done=0, spike_count=0.
//     - Internals: acc=0, win_cnt=0, level=0, mode_q=0, lfsr=LFSR_SEED.
//     - Reset mid-window aborts it: no done pulse, count cleared.
//   - FSM, 2 states.
//     - IDLE (busy=0): start&&ena at edge E0 latches intensity->level and mode->mode_q,
//       clears acc/win_cnt/spike_count, enters RUN (busy=1 after E0).
//     - RUN: each edge with ena=1 is a window cycle. spike_out registers the spike
//       decision, so latency is 1 cycle. Edges E1..E_WINDOW.
//     - RUN: at E_WINDOW -> IDLE, busy<=0, done<=1 for exactly one cycle.
//   - start while busy is ignored, never queued. start in the cycle done=1 (busy=0) is
//     accepted and done still deasserts next edge.
//   - Deterministic spike decision: sum = {1'b0,acc}+level (WIDTH+1 bits);
//     spike = sum[WIDTH]; acc <= sum[WIDTH-1:0].
//     - Emits exactly floor(n*level/2^WIDTH) spikes after n window cycles.
//     - level=0 -> 0 spikes; level=255, WINDOW=256 -> 255 spikes.
//   - Stochastic spike decision: spike = (lfsr[WIDTH-1:0] < level).
//     - LFSR is 16-bit Fibonacci, taps 16,14,13,11; shifts once per window cycle only.
//     - Not reseeded on start (sequence continues across windows), reseeded only by reset.
//   - spike_count increments on every window cycle whose registered spike is 1,
//     including E_WINDOW. It holds after done until the next start accept.
//     - Never wraps: the width covers WINDOW.
//   - spike_out<=0 on every edge not in RUN, so it is 0 from the edge after E_WINDOW
//     and in IDLE.
//   - ena=0 during RUN freezes acc/lfsr/win_cnt/spike_count and forces spike_out<=0.
//     The window stretches; the spike total is unchanged.
//   - ena=0 in IDLE blocks start accept.
//   - intensity/mode changes during RUN have no effect.
// STRUCTURE
//   - lif_pkg (shared package):
//     - MODE_DET/MODE_STOCH enum
//     - LFSR_TAPS
//     - LFSR_SEED default
//     - state enum {ST_IDLE, ST_RUN}
//   - Sub-module lif_lfsr16 (clk, rst_n, adv, q[15:0]) holds the LFSR.
//     Reused by the neuron noise source.
//   - Top of tile wires spike_out into the neuron's signal_in; done/busy go to uio.
// TESTING
//   1. rst_n=0 for 3 clk mid-RUN -> all outputs 0 next edge, no done, busy=0.
//   2. mode=0, intensity=64, start 1 clk -> busy for 256 cycles, spikes exactly every
//      4th cycle (first at E4), done pulse 1 clk, spike_count=64.
//   3. mode=0, intensity=0 -> spike_out never 1, count=0.
//      intensity=255 -> count=255, single gap at E1.
//   4. mode=1, intensity=128, 8 back-to-back windows -> each count within 128+/-24,
//      exact counts match C model of the LFSR from LFSR_SEED.
//   5. start held high continuously with intensity=32 -> windows restart on each done
//      cycle, one accept per window, count=32 each.
//   6. mode=0, intensity=128, ena low 10 cycles at E50 -> spike_out=0 while low,
//      done delayed 10 cycles, count=128.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF spike interface (encoder and neuron noise source).
package lif_pkg;

  typedef enum logic {MODE_DET = 1'b0, MODE_STOCH = 1'b1} mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS     = 16'h002D;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {^(q & LFSR_TAPS), q[15:1]};
  endfunction

endpackage

// File: rtl/lif_lfsr16.sv
// 16-bit maximal-length LFSR; advances one step on each edge with adv_i high.
module lif_lfsr16
  import lif_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        adv_i,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/lif_spike_rate_encoder.sv
// Turns an intensity into a spike train over a fixed window, either by phase
// accumulation (exact rate) or by LFSR comparison (Poisson-like).
module lif_spike_rate_encoder
  import lif_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          WINDOW    = 256,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
  localparam int         CW        = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  input  logic [WIDTH-1:0] intensity_i,
  input  logic             mode_i,
  input  logic             start_i,
  output logic             spike_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CW-1:0]    spike_count_o
);

  localparam logic [15:0] LO_MASK = 16'((1 << WIDTH) - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    win_cnt_q, win_cnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             spike_q, spike_d;
  logic             done_q, done_d;

  logic [15:0]      lfsr_q;
  logic             lfsr_adv;
  logic [WIDTH:0]   sum;
  logic             stoch_hit;
  logic             hit;

  lif_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv_i (lfsr_adv),
    .q_o   (lfsr_q)
  );

  assign sum       = {1'b0, acc_q} + {1'b0, level_q};
  assign stoch_hit = (lfsr_q & LO_MASK) < 16'(level_q);
  assign hit       = (mode_q == MODE_STOCH) ? stoch_hit : sum[WIDTH];

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    level_d   = level_q;
    acc_d     = acc_q;
    win_cnt_d = win_cnt_q;
    cnt_d     = cnt_q;
    spike_d   = 1'b0;
    done_d    = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && ena_i) begin
          level_d   = intensity_i;
          mode_d    = mode_e'(mode_i);
          acc_d     = '0;
          win_cnt_d = '0;
          cnt_d     = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // ena low stretches the window: nothing advances, spike_out forced low.
        if (ena_i) begin
          lfsr_adv = 1'b1;
          spike_d  = hit;
          cnt_d    = cnt_q + CW'(hit);
          if (mode_q == MODE_DET) acc_d = sum[WIDTH-1:0];
          if (win_cnt_q == CW'(WINDOW - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_DET;
      level_q   <= '0;
      acc_q     <= '0;
      win_cnt_q <= '0;
      cnt_q     <= '0;
      spike_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      level_q   <= level_d;
      acc_q     <= acc_d;
      win_cnt_q <= win_cnt_d;
      cnt_q     <= cnt_d;
      spike_q   <= spike_d;
      done_q    <= done_d;
    end
  end

  assign spike_out_o   = spike_q;
  assign busy_o        = (state_q == ST_RUN);
  assign done_o        = done_q;
  assign spike_count_o = cnt_q;

endmodule

// File: tb/tb_lif_spike_rate_encoder.sv
// Directed bench for the spike rate encoder: reset, deterministic rates, stochastic windows, start/ena handling.
module tb_lif_spike_rate_encoder;

  localparam int WIN = 256;
  localparam int CW  = 9;

  logic          clk = 1'b0;
  logic          rst_n, ena, mode, start;
  logic [7:0]    intensity;
  logic          spike_out, busy, done;
  logic [CW-1:0] spike_count;

  int n_cmp = 0;
  int n_bad = 0;

  bit            obs_spk [WIN];
  int            o_nsp, o_ncyc, o_busy_bad, o_done_bad, o_frz_bad;
  bit            o_timeout;
  logic          o_done, o_busy;
  logic [CW-1:0] o_cnt;

  lif_spike_rate_encoder #(.WIDTH(8), .WINDOW(WIN), .LFSR_SEED(16'hACE1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena_i         (ena),
    .intensity_i   (intensity),
    .mode_i        (mode),
    .start_i       (start),
    .spike_out_o   (spike_out),
    .busy_o        (busy),
    .done_o        (done),
    .spike_count_o (spike_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a start, then steps until WIN enabled window cycles have elapsed,
  // recording the spike seen after each one. Inputs are scrambled after accept.
  task automatic run_window(input logic [7:0] lvl, input logic md, input bit hold,
                            input int gap_at, input int gap_len);
    int k;
    int g;
    k = 0; g = 0;
    o_nsp = 0; o_ncyc = 0; o_busy_bad = 0; o_done_bad = 0; o_frz_bad = 0;
    intensity = lvl; mode = md; start = 1'b1; ena = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    intensity = ~lvl; mode = ~md;
    while (k < WIN && o_ncyc < WIN + 64) begin
      ena = !(k == gap_at && g < gap_len);
      if (!ena) g++;
      tick();
      o_ncyc++;
      if (ena) begin
        obs_spk[k] = spike_out;
        o_nsp += int'(spike_out);
        k++;
      end else if (spike_out !== 1'b0) begin
        o_frz_bad++;
      end
      if (k < WIN && busy !== 1'b1) o_busy_bad++;
      if (k < WIN && done !== 1'b0) o_done_bad++;
    end
    o_timeout = (k < WIN);
    ena = 1'b1;
    o_done = done; o_busy = busy; o_cnt = spike_count;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; ena = 1'b0; start = 1'b0; mode = 1'b0; intensity = 8'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    n_cmp++; if (spike_out !== 1'b0) begin n_bad++; $display("FAIL reset_spike got %b want 0", spike_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (spike_count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", spike_count); end
    intensity = 8'd200; mode = 1'b0; start = 1'b1; ena = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    n_cmp++; if (busy !== 1'b1 || spike_count === '0) begin n_bad++; $display("FAIL midrun_active busy=%b count=%0d want busy=1 count>0", busy, spike_count); end
    rst_n = 1'b0;
    tick();
    n_cmp++; if ({spike_out, busy, done, spike_count} !== '0) begin n_bad++; $display("FAIL midrun_reset got spk=%b busy=%b done=%b cnt=%0d want all 0", spike_out, busy, done, spike_count); end
    repeat (2) tick();
    rst_n = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL reset_no_done got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_stoch_back_to_back();
    logic [15:0] l;
    int          exp_cnt;
    logic        fb;
    l = 16'hACE1;
    for (int w = 0; w < 8; w++) begin
      exp_cnt = 0;
      for (int c = 0; c < WIN; c++) begin
        if (l[7:0] < 8'd128) exp_cnt++;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        l  = {fb, l[15:1]};
      end
      run_window(8'd128, 1'b1, 1'b0, -1, 0);
      n_cmp++; if (o_timeout || o_done !== 1'b1) begin n_bad++; $display("FAIL stoch_done w%0d got done=%b timeout=%0d want done=1", w, o_done, o_timeout); end
      n_cmp++; if (int'(o_cnt) !== exp_cnt) begin n_bad++; $display("FAIL stoch_count w%0d got %0d want %0d", w, o_cnt, exp_cnt); end
      n_cmp++; if (o_cnt < 9'd104 || o_cnt > 9'd152) begin n_bad++; $display("FAIL stoch_range w%0d got %0d want 104..152", w, o_cnt); end
    end
  endtask

  task automatic test_det64();
    int bad;
    run_window(8'd64, 1'b0, 1'b0, -1, 0);
    bad = 0;
    for (int k = 0; k < WIN; k++) if (obs_spk[k] != ((k + 1) % 4 == 0)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL det64_pattern got %0d bad cycles want 0", bad); end
    n_cmp++; if (o_ncyc !== WIN || o_busy_bad !== 0 || o_done_bad !== 0) begin n_bad++; $display("FAIL det64_busy got ncyc=%0d busy_bad=%0d done_bad=%0d want 256/0/0", o_ncyc, o_busy_bad, o_done_bad); end
    n_cmp++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin n_bad++; $display("FAIL det64_done got done=%b busy=%b want 1/0", o_done, o_busy); end
    n_cmp++; if (o_cnt !== 9'd64) begin n_bad++; $display("FAIL det64_count got %0d want 64", o_cnt); end
    tick();
    n_cmp++; if (done !== 1'b0 || spike_out !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL det64_after got done=%b spk=%b busy=%b want 0/0/0", done, spike_out, busy); end
    n_cmp++; if (spike_count !== 9'd64) begin n_bad++; $display("FAIL det64_hold got %0d want 64", spike_count); end
  endtask

  task automatic test_det_edges();
    int bad;
    run_window(8'd0, 1'b0, 1'b0, -1, 0);
    n_cmp++; if (o_nsp !== 0 || o_cnt !== 9'd0) begin n_bad++; $display("FAIL det0 got spikes=%0d cnt=%0d want 0/0", o_nsp, o_cnt); end
    tick();
    run_window(8'd255, 1'b0, 1'b0, -1, 0);
    bad = 0;
    for (int k = 0; k < WIN; k++) if (obs_spk[k] != (k != 0)) bad++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL det255_pattern got %0d bad cycles want 0", bad); end
    n_cmp++; if (o_cnt !== 9'd255) begin n_bad++; $display("FAIL det255_count got %0d want 255", o_cnt); end
    tick();
  endtask

  task automatic test_start_held();
    int bad;
    start = 1'b1;
    for (int w = 0; w < 4; w++) begin
      run_window(8'd32, 1'b0, 1'b1, -1, 0);
      bad = 0;
      for (int k = 0; k < WIN; k++) if (obs_spk[k] != ((k + 1) % 8 == 0)) bad++;
      n_cmp++; if (o_cnt !== 9'd32 || bad !== 0) begin n_bad++; $display("FAIL held_count w%0d got cnt=%0d bad=%0d want 32/0", w, o_cnt, bad); end
      n_cmp++; if (o_ncyc !== WIN || o_busy_bad !== 0 || o_done !== 1'b1) begin n_bad++; $display("FAIL held_window w%0d got ncyc=%0d busy_bad=%0d done=%b want 256/0/1", w, o_ncyc, o_busy_bad, o_done); end
    end
    start = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL held_release got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_ena_freeze();
    int bad;
    run_window(8'd128, 1'b0, 1'b0, 50, 10);
    bad = 0;
    for (int k = 0; k < WIN; k++) if (obs_spk[k] != ((k + 1) % 2 == 0)) bad++;
    n_cmp++; if (o_frz_bad !== 0) begin n_bad++; $display("FAIL ena_spike_low got %0d bad cycles want 0", o_frz_bad); end
    n_cmp++; if (o_ncyc !== WIN + 10 || o_done !== 1'b1) begin n_bad++; $display("FAIL ena_stretch got ncyc=%0d done=%b want 266/1", o_ncyc, o_done); end
    n_cmp++; if (o_cnt !== 9'd128 || bad !== 0) begin n_bad++; $display("FAIL ena_count got cnt=%0d bad=%0d want 128/0", o_cnt, bad); end
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stoch_back_to_back();
    test_det64();
    test_det_edges();
    test_start_held();
    test_ena_freeze();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
